// File: rtl/lsu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit between a RISC-V core and a
// 64-bit doubleword bus.
//
// A request is taken in IDLE and checked for legality in the same cycle.
// Illegal requests skip the bus and complete with resp_err. Legal ones
// present one bus beat in REQ. Stores complete on the bus handshake. Loads
// wait in WAIT for mem_rvalid, then extract and extend the addressed bytes.
// Every transaction ends with a single-cycle resp_valid pulse in RESP.
//
// Ports
//   clk, rst        sole clock; synchronous active-high reset
//   req_*           core request (valid/ready, we, funct3, byte addr, wdata)
//   resp_*          completion pulse, extended load data, error flag
//   mem_valid/ready bus request handshake
//   mem_addr        doubleword-aligned address
//   mem_we          bus write, only while mem_valid
//   mem_wmask       byte-lane enables, bit i = byte i (little-endian)
//   mem_wdata       lane-shifted store data
//   mem_rvalid      read data valid, only honoured in WAIT
//   mem_rdata       aligned doubleword read data
//
// Configuration
//   LSU_MISALIGN_CHECK_EN  defined: an H/W/D access whose byte offset is not
//                          a multiple of its size completes with resp_err
//                          and never reaches the bus.
//                          undefined: the offset is rounded down to natural
//                          alignment and the access proceeds.
// -----------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // funct3[1:0] encodes the access size; funct3[2] selects zero-extension.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Stores have no unsigned variants; loads only lack a "LDU".
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        return we ? f3[2] : (f3 == 3'b111);
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic m;
        m = 1'b0;
        case (size)
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            SZ_D:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    // Natural-alignment rounding. With the misalignment check enabled only
    // aligned accesses ever reach the bus, so this is then an identity.
    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] a;
        a = off;
        case (size)
            SZ_B:    a = off;
            SZ_H:    a = {off[2:1], 1'b0};
            SZ_W:    a = {off[2], 2'b00};
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_e      state_q,  state_d;
    logic        we_q,     we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q,   addr_d;
    logic [63:0] wdata_q,  wdata_d;
    logic [63:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        accept;
    logic        req_err;
    logic [2:0]  off;
    logic [7:0]  store_mask;
    logic [63:0] store_data;
    logic [63:0] load_shifted;
    logic [63:0] load_data;

    assign accept = req_valid & req_ready;

    // Legality of the incoming request, evaluated in the accept cycle.
    always_comb begin
        req_err = funct3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
        req_err = req_err | misaligned(req_funct3[1:0], req_addr[2:0]);
`endif
    end

    // -------------------------------------------------------------------------
    // Lane steering, derived from the latched request
    // -------------------------------------------------------------------------
    assign off = align_off(funct3_q[1:0], addr_q[2:0]);

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first;
        // a path that leaves it unassigned would otherwise infer a latch.
        store_mask = 8'h00;
        case (funct3_q[1:0])
            SZ_B:    store_mask = 8'h01 << off;
            SZ_H:    store_mask = 8'h03 << off;
            SZ_W:    store_mask = 8'h0F << off;
            default: store_mask = 8'hFF;
        endcase
    end

    // Bits pushed above bit 63 are intentionally dropped.
    assign store_data   = wdata_q << {off, 3'b000};
    assign load_shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        load_data = 64'd0;
        case (funct3_q)
            3'b000:  load_data = {{56{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_data = {{48{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_data = {{32{load_shifted[31]}}, load_shifted[31:0]};
            3'b011:  load_data = load_shifted;
            3'b100:  load_data = {56'd0, load_shifted[7:0]};
            3'b101:  load_data = {48'd0, load_shifted[15:0]};
            3'b110:  load_data = {32'd0, load_shifted[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)     state_d = req_err ? S_RESP : S_REQ;
            S_REQ:  if (mem_ready)  state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid) state_d = S_RESP;
            S_RESP:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (bus fields are zero whenever no beat is offered)
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !rst;
        mem_valid  = (state_q == S_REQ);
        mem_we     = mem_valid & we_q;
        mem_addr   = mem_valid ? {addr_q[63:3], 3'b000} : 64'd0;
        mem_wmask  = mem_we ? store_mask : 8'h00;
        mem_wdata  = mem_we ? store_data : 64'd0;
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid & err_q;
        resp_rdata = resp_valid ? rdata_q : 64'd0;
    end

    // -------------------------------------------------------------------------
    // Request / response datapath
    // -------------------------------------------------------------------------
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (state_q == S_IDLE && accept) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            err_d    = req_err;
            // Cleared here so stores and errors report zero data.
            rdata_d  = 64'd0;
        end else if (state_q == S_WAIT && mem_rvalid) begin
            rdata_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset as well as the state so no stale
        // request survives a reset; it is small enough that this is free.
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge. Expected values come from a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: works on whole bytes and access sizes in bytes.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  input logic [63:0] rdata,
                                  output logic err, output logic [63:0] maddr,
                                  output logic [7:0] mask, output logic [63:0] mwdata,
                                  output logic [63:0] lrdata);
        int size;
        int off;
        logic [63:0] v;
        size   = 1 << f3[1:0];
        off    = int'(addr[2:0]);
        err    = we ? (f3 >= 3'd4) : (f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % size != 0) err = 1'b1;
`endif
        off    = off - (off % size);
        maddr  = addr & ~64'h7;
        mask   = 8'h00;
        mwdata = 64'd0;
        lrdata = 64'd0;
        v      = 64'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mask[off + i] = 1'b1;
            for (int i = off; i < 8; i++) mwdata[8*i +: 8] = wdata[8*(i - off) +: 8];
        end else begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
            if (!f3[2] && size < 8 && v[8*size - 1])
                for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
            lrdata = v;
        end
    endfunction

    // One complete transaction, starting and ending on a falling edge in IDLE.
    // stall: cycles mem_ready stays low; delay: WAIT cycles before mem_rvalid.
    task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] bus_rdata, input int stall, input int delay);
        logic        e_err;
        logic [63:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        model(we, f3, addr, wdata, bus_rdata, e_err, e_addr, e_mask, e_wdata, e_rdata);

        check({name, ".ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_wdata  = {$urandom, $urandom};
        req_addr   = {$urandom, $urandom};

        if (e_err) begin
            check({name, ".err_valid"}, resp_valid, 1);
            check({name, ".err_flag"}, resp_err, 1);
            check({name, ".err_rdata"}, resp_rdata, 0);
            check({name, ".err_nobus"}, mem_valid, 0);
        end else begin
            for (int s = 0; s <= stall; s++) begin
                check({name, ".mem_valid"}, mem_valid, 1);
                check({name, ".mem_addr"}, mem_addr, e_addr);
                check({name, ".mem_we"}, mem_we, we);
                check({name, ".mem_wmask"}, mem_wmask, e_mask);
                check({name, ".mem_wdata"}, mem_wdata, e_wdata);
                check({name, ".early_resp"}, resp_valid, 0);
                mem_ready  = (s == stall);
                // Stray read beats outside WAIT must be ignored.
                mem_rvalid = 1'($urandom);
                mem_rdata  = {$urandom, $urandom};
                @(negedge clk);
            end
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!we) begin
                for (int w = 0; w <= delay; w++) begin
                    check({name, ".wait_nobus"}, mem_valid, 0);
                    check({name, ".wait_noresp"}, resp_valid, 0);
                    mem_rvalid = (w == delay);
                    mem_rdata  = (w == delay) ? bus_rdata : {$urandom, $urandom};
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                mem_rdata  = {$urandom, $urandom};
            end
            check({name, ".resp_valid"}, resp_valid, 1);
            check({name, ".resp_err"}, resp_err, 0);
            check({name, ".resp_rdata"}, resp_rdata, e_rdata);
            check({name, ".resp_nobus"}, mem_valid, 0);
        end
        @(negedge clk);
        check({name, ".single_pulse"}, resp_valid, 0);
        check({name, ".ready_again"}, req_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.req_ready", req_ready, 0);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.resp_err", resp_err, 0);
        check("rst.resp_rdata", resp_rdata, 0);
        check("rst.mem_valid", mem_valid, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_wmask", mem_wmask, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.ready", req_ready, 1);

        // Directed cases
        run_access("sd",   1'b1, 3'b011, 64'h8000_1000, 64'h1122_3344_5566_7788, 64'd0, 0, 0);
        run_access("sb",   1'b1, 3'b000, 64'h8000_1005, 64'h0000_0000_0000_00AB, 64'd0, 0, 0);
        run_access("lb",   1'b0, 3'b000, 64'h8000_1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        run_access("lbu",  1'b0, 3'b100, 64'h8000_1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        run_access("lw_stall", 1'b0, 3'b010, 64'h8000_1004, 64'd0, 64'hDEAD_BEEF_1234_5678, 3, 1);
        run_access("lh_mis", 1'b0, 3'b001, 64'h8000_1001, 64'd0, 64'hCAFE_F00D_0BAD_8001, 0, 0);
        run_access("sw_mis", 1'b1, 3'b010, 64'h8000_1006, 64'h0000_0000_A5A5_5A5A, 64'd0, 1, 0);
        run_access("ld",   1'b0, 3'b011, 64'h8000_1008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 2);
        run_access("lwu",  1'b0, 3'b110, 64'h8000_1004, 64'd0, 64'h8765_4321_0000_0000, 1, 0);
        run_access("ill_ld", 1'b0, 3'b111, 64'h8000_1000, 64'd0, 64'd0, 0, 0);
        run_access("ill_st", 1'b1, 3'b100, 64'h8000_1000, 64'hFFFF, 64'd0, 0, 0);

        // Reset while a load sits in WAIT, then a stray read beat
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h8000_2000;
        @(negedge clk);
        req_valid  = 1'b0;
        mem_ready  = 1'b1;
        @(negedge clk);
        mem_ready  = 1'b0;
        check("rwait.in_wait", mem_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rwait.ready_in_rst", req_ready, 0);
        check("rwait.no_resp", resp_valid, 0);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rwait.stray_no_resp", resp_valid, 0);
        check("rwait.ready", req_ready, 1);
        @(negedge clk);
        check("rwait.still_no_resp", resp_valid, 0);
        check("rwait.still_ready", req_ready, 1);

        // Randomized accesses
        for (int k = 0; k < 80; k++) begin
            run_access("rnd", 1'($urandom), 3'($urandom), {$urandom, $urandom},
                       {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have port clk, in, 1: sole clock, all state updates on posedge.
REQ-002 SHALL have port rst, in, 1: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, in, 1: core presents a load/store.
REQ-004 SHALL have port req_ready, out, 1: LSU accepts a request this cycle.
REQ-005 SHALL have port req_we, in, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, in, 3: RISC-V funct3 size/sign code.
REQ-007 SHALL have port req_addr, in, 64: byte address.
REQ-008 SHALL have port req_wdata, in, 64: store data, right-aligned.
REQ-009 SHALL have port resp_valid, out, 1: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, out, 64: extended load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err, out, 1: illegal funct3 or misaligned access; qualified by resp_valid.
REQ-012 SHALL have port mem_valid, out, 1: bus request.
REQ-013 SHALL have port mem_ready, in, 1: bus accepts the request.
REQ-014 SHALL have port mem_addr, out, 64: {req_addr[63:3],3'b000}.
REQ-015 SHALL have port mem_we, out, 1: bus write.
REQ-016 SHALL have port mem_wmask, out, 8: byte-lane enables, bit i = byte i (little-endian).
REQ-017 SHALL have port mem_wdata, out, 64: lane-shifted store data.
REQ-018 SHALL have port mem_rvalid, in, 1: read data valid.
REQ-019 SHALL have port mem_rdata, in, 64: aligned doubleword read data.

Function
REQ-020 SHALL implement FSM IDLE, REQ, WAIT, RESP; req_ready = 1 only in IDLE and rst low.
REQ-021 SHALL latch req_we, req_funct3, req_addr and req_wdata on req_valid & req_ready; the request is legal-checked in the same cycle.
REQ-022 SHALL go IDLE->RESP with resp_err = 1 and no bus activity when funct3 is illegal: loads 3'b111; stores with funct3[2] = 1.
REQ-023 SHALL otherwise go IDLE->REQ, holding mem_valid and all mem_* outputs stable until mem_ready = 1.
REQ-024 SHALL, on the mem_valid & mem_ready handshake, go REQ->RESP for stores and REQ->WAIT for loads.
REQ-025 SHALL ignore mem_rvalid outside WAIT; in WAIT it SHALL capture mem_rdata when mem_rvalid = 1 and go to RESP.
REQ-026 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 SHALL meet minimum latency (accept cycle = 0): store resp_valid at cycle 2; load resp_valid at cycle 3 when mem_ready and mem_rvalid are never stalled.
REQ-028 SHALL use off = addr[2:0] for the byte offset. mem_wmask SHALL be 8'h01<<off for SB, 8'h03<<off for SH, 8'h0F<<off for SW, and 8'hFF for SD.
REQ-029 SHALL drive mem_wdata = req_wdata << (8*off), with bits shifted above bit 63 dropped.
REQ-030 SHALL extract load data as (mem_rdata >> 8*off) truncated to 8/16/32/64 bits. LB/LH/LW SHALL sign-extend; LBU/LHU/LWU SHALL zero-extend; LD SHALL pass through unchanged.
REQ-031 SHALL drive mem_wmask = 0 and mem_wdata = 0 on load requests; mem_we SHALL equal the latched req_we while mem_valid = 1, else 0.

Reset
REQ-032 SHALL, when rst = 1 at a clock edge, force state IDLE. It SHALL also force req_ready, resp_valid, resp_err, mem_valid and mem_we to 0, and resp_rdata, mem_addr, mem_wmask and mem_wdata to 0.
REQ-033 SHALL abandon any in-flight transaction on reset mid-operation, with no resp_valid. A late mem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-034 SHALL honour macro LSU_MISALIGN_CHECK_EN.
- Defined: an access whose off is not a multiple of the access size (2/4/8 bytes for H/W/D) SHALL go IDLE->RESP with resp_err = 1, resp_rdata = 0 and no mem_valid.
- Undefined: off SHALL be rounded down to natural alignment, the access SHALL proceed, and resp_err SHALL be raised only for illegal funct3.

Verification
REQ-035 SHALL pass: SD addr 0x80001000, data 0x1122334455667788, mem_ready tied 1 -> mem_wmask 8'hFF, mem_addr 0x80001000, resp_valid at cycle 2, resp_err 0.
REQ-036 SHALL pass: SB addr 0x80001005, data 0xAB -> mem_wmask 8'h20, mem_wdata 0x0000AB0000000000.
REQ-037 SHALL pass: LB addr 0x80001003, mem_rdata 0x0000000080000000 -> resp_rdata 0xFFFFFFFFFFFFFF80; the same access with LBU -> 0x80.
REQ-038 SHALL pass: LW addr 0x80001004, mem_ready low 3 cycles, then mem_rvalid 2 cycles after the handshake -> mem_outputs stable while stalled, one resp_valid, correct data, and no second pulse.
REQ-039 SHALL pass: LH addr 0x80001001 -> resp_err 1 with no mem_valid when LSU_MISALIGN_CHECK_EN is defined; a bus read at offset 0 when it is undefined.
REQ-040 SHALL pass: rst asserted in WAIT followed by a stray mem_rvalid -> state IDLE, no resp_valid, req_ready 1 one cycle after rst drops.
